rc_mt_req_trk: RTL

Parametrised multi-thread request tracker for the ring controller, sitting between the core's C2F interface and the ring. It queues core requests in a DEPTH-entry FIFO, inserts them into free ring request slots, tracks one outstanding transaction per thread, and pulls matching responses off the ring back to the core. It also provides an optional per-thread response timeout.

---
 rtl/rc_mt_req_trk.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/rc_mt_req_trk.sv
// rtl/rc_mt_req_trk.sv - multi-thread C2F/ring request tracker; optional response timeout under RC_RSP_TIMEOUT_EN
// Opcode encoding: RD=0, WR=1, RD_RSP=2, WR_RSP=3.
module rc_mt_req_trk #(
    parameter int THREAD_W    = 2,
    parameter int CORE_ID_W   = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255,
    localparam int RQ_W       = CORE_ID_W + THREAD_W,
    localparam int OP_W       = 2
) (
    input  logic                 QClk,
    input  logic                 RstQnnnH,
    input  logic [CORE_ID_W-1:0] CoreID,
    input  logic                 C2F_ReqValidQ500H,
    input  logic [OP_W-1:0]      C2F_ReqOpcodeQ500H,
    input  logic [THREAD_W-1:0]  C2F_ReqThreadIDQ500H,
    input  logic [31:0]          C2F_ReqAddressQ500H,
    input  logic [31:0]          C2F_ReqDataQ500H,
    output logic                 C2F_RspStall,
    output logic                 C2F_RspValidQ502H,
    output logic [OP_W-1:0]      C2F_RspOpcodeQ502H,
    output logic [THREAD_W-1:0]  C2F_RspThreadIDQ502H,
    output logic [31:0]          C2F_RspDataQ502H,
    input  logic                 RingReqInValidQ500H,
    input  logic [RQ_W-1:0]      RingReqInRequestorQ500H,
    input  logic [OP_W-1:0]      RingReqInOpcodeQ500H,
    input  logic [31:0]          RingReqInAddressQ500H,
    input  logic [31:0]          RingReqInDataQ500H,
    output logic                 RingReqOutValidQ502H,
    output logic [RQ_W-1:0]      RingReqOutRequestorQ502H,
    output logic [OP_W-1:0]      RingReqOutOpcodeQ502H,
    output logic [31:0]          RingReqOutAddressQ502H,
    output logic [31:0]          RingReqOutDataQ502H,
    input  logic                 RingRspInValidQ500H,
    input  logic [RQ_W-1:0]      RingRspInRequestorQ500H,
    input  logic [OP_W-1:0]      RingRspInOpcodeQ500H,
    input  logic [31:0]          RingRspInAddressQ500H,
    input  logic [31:0]          RingRspInDataQ500H,
    output logic                 RingRspOutValidQ502H,
    output logic [RQ_W-1:0]      RingRspOutRequestorQ502H,
    output logic [OP_W-1:0]      RingRspOutOpcodeQ502H,
    output logic [31:0]          RingRspOutAddressQ502H,
    output logic [31:0]          RingRspOutDataQ502H
);
    localparam int NUM_THREADS = 2 ** THREAD_W;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam logic [OP_W-1:0] OP_RD_RSP = 2'd2;

    // The FIFO storage itself is the Q501H stage of the core request.
    logic [OP_W-1:0]     fifoOp   [DEPTH];
    logic [THREAD_W-1:0] fifoTid  [DEPTH];
    logic [31:0]         fifoAddr [DEPTH];
    logic [31:0]         fifoData [DEPTH];
    logic [PTR_W-1:0]    rdPtr, wrPtr;
    logic [PTR_W:0]      count, nextCount;
    logic [NUM_THREADS-1:0] pending, pendingNext;

    logic                reqInValid, rspInValid;
    logic [RQ_W-1:0]     reqInRq, rspInRq;
    logic [OP_W-1:0]     reqInOp, rspInOp;
    logic [31:0]         reqInAddr, reqInData, rspInAddr, rspInData;

    logic                push, pop, rspOwn, match, toFire, timeoutFire;
    logic [THREAD_W-1:0] headTid, rspTid, toTid;

    assign headTid     = fifoTid[rdPtr];
    assign rspTid      = rspInRq[THREAD_W-1:0];
    assign push        = C2F_ReqValidQ500H & ~C2F_RspStall;
    assign pop         = ~reqInValid & (count != '0) & ~pending[headTid];
    assign rspOwn      = rspInValid & (rspInRq[RQ_W-1:THREAD_W] == CoreID);
    assign match       = rspOwn & pending[rspTid];
    assign timeoutFire = toFire & ~match;
    assign nextCount   = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

`ifdef RC_RSP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] toCnt [NUM_THREADS];

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            for (int t = 0; t < NUM_THREADS; t++) toCnt[t] <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (pop && headTid == THREAD_W'(t))
                    toCnt[t] <= '0;
                else if (pending[t] && toCnt[t] != TO_W'(TIMEOUT_CYC))
                    toCnt[t] <= toCnt[t] + TO_W'(1);
            end
        end
    end

    // Scan downwards so the lowest saturated thread is the one reported.
    always_comb begin
        toFire = 1'b0;
        toTid  = '0;
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            if (pending[t] && toCnt[t] == TO_W'(TIMEOUT_CYC)) begin
                toFire = 1'b1;
                toTid  = THREAD_W'(t);
            end
        end
    end
`else
    assign toFire = 1'b0;
    assign toTid  = '0;
`endif

    always_comb begin
        pendingNext = pending;
        if (match)       pendingNext[rspTid]  = 1'b0;
        if (timeoutFire) pendingNext[toTid]   = 1'b0;
        if (pop)         pendingNext[headTid] = 1'b1;
    end

    always_ff @(posedge QClk) begin
        if (push) begin
            fifoOp[wrPtr]   <= C2F_ReqOpcodeQ500H;
            fifoTid[wrPtr]  <= C2F_ReqThreadIDQ500H;
            fifoAddr[wrPtr] <= C2F_ReqAddressQ500H;
            fifoData[wrPtr] <= C2F_ReqDataQ500H;
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            count        <= '0;
            rdPtr        <= '0;
            wrPtr        <= '0;
            pending      <= '0;
            C2F_RspStall <= 1'b0;
            reqInValid   <= 1'b0;
            reqInRq      <= '0;
            reqInOp      <= '0;
            reqInAddr    <= '0;
            reqInData    <= '0;
            rspInValid   <= 1'b0;
            rspInRq      <= '0;
            rspInOp      <= '0;
            rspInAddr    <= '0;
            rspInData    <= '0;
        end else begin
            count        <= nextCount;
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            pending      <= pendingNext;
            C2F_RspStall <= (nextCount == (PTR_W+1)'(DEPTH));
            reqInValid   <= RingReqInValidQ500H;
            reqInRq      <= RingReqInRequestorQ500H;
            reqInOp      <= RingReqInOpcodeQ500H;
            reqInAddr    <= RingReqInAddressQ500H;
            reqInData    <= RingReqInDataQ500H;
            rspInValid   <= RingRspInValidQ500H;
            rspInRq      <= RingRspInRequestorQ500H;
            rspInOp      <= RingRspInOpcodeQ500H;
            rspInAddr    <= RingRspInAddressQ500H;
            rspInData    <= RingRspInDataQ500H;
        end
    end

    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            RingReqOutValidQ502H     <= 1'b0;
            RingReqOutRequestorQ502H <= '0;
            RingReqOutOpcodeQ502H    <= '0;
            RingReqOutAddressQ502H   <= '0;
            RingReqOutDataQ502H      <= '0;
            RingRspOutValidQ502H     <= 1'b0;
            RingRspOutRequestorQ502H <= '0;
            RingRspOutOpcodeQ502H    <= '0;
            RingRspOutAddressQ502H   <= '0;
            RingRspOutDataQ502H      <= '0;
            C2F_RspValidQ502H        <= 1'b0;
            C2F_RspOpcodeQ502H       <= '0;
            C2F_RspThreadIDQ502H     <= '0;
            C2F_RspDataQ502H         <= '0;
        end else begin
            // Upstream traffic owns the slot; our head only fills empty slots.
            if (reqInValid) begin
                RingReqOutValidQ502H     <= 1'b1;
                RingReqOutRequestorQ502H <= reqInRq;
                RingReqOutOpcodeQ502H    <= reqInOp;
                RingReqOutAddressQ502H   <= reqInAddr;
                RingReqOutDataQ502H      <= reqInData;
            end else if (pop) begin
                RingReqOutValidQ502H     <= 1'b1;
                RingReqOutRequestorQ502H <= {CoreID, headTid};
                RingReqOutOpcodeQ502H    <= fifoOp[rdPtr];
                RingReqOutAddressQ502H   <= fifoAddr[rdPtr];
                RingReqOutDataQ502H      <= fifoData[rdPtr];
            end else begin
                RingReqOutValidQ502H     <= 1'b0;
                RingReqOutRequestorQ502H <= '0;
                RingReqOutOpcodeQ502H    <= '0;
                RingReqOutAddressQ502H   <= '0;
                RingReqOutDataQ502H      <= '0;
            end

            // Own-core responses never travel on, matched or stale.
            RingRspOutValidQ502H     <= rspInValid & ~rspOwn;
            RingRspOutRequestorQ502H <= rspInRq;
            RingRspOutOpcodeQ502H    <= rspInOp;
            RingRspOutAddressQ502H   <= rspInAddr;
            RingRspOutDataQ502H      <= rspInData;

            if (match) begin
                C2F_RspValidQ502H    <= 1'b1;
                C2F_RspOpcodeQ502H   <= rspInOp;
                C2F_RspThreadIDQ502H <= rspTid;
                C2F_RspDataQ502H     <= rspInData;
            end else if (timeoutFire) begin
                C2F_RspValidQ502H    <= 1'b1;
                C2F_RspOpcodeQ502H   <= OP_RD_RSP;
                C2F_RspThreadIDQ502H <= toTid;
                C2F_RspDataQ502H     <= 32'hDEAD_BEEF;
            end else begin
                C2F_RspValidQ502H    <= 1'b0;
                C2F_RspOpcodeQ502H   <= '0;
                C2F_RspThreadIDQ502H <= '0;
                C2F_RspDataQ502H     <= '0;
            end
        end
    end
endmodule
